// File: rtl/e203_dtcm_sram_ctrl_if.sv
// ICB command/response channel plus SRAM macro pins of the DTCM controller.
// "master" is the requester together with the SRAM macro; "slave" is the controller.
interface e203_dtcm_sram_ctrl_if #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          icb_cmd_valid;
    logic          icb_cmd_ready;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_cmd_read;
    logic [DW-1:0] icb_cmd_wdata;
    logic [MW-1:0] icb_cmd_wmask;

    logic          icb_rsp_valid;
    logic          icb_rsp_ready;
    logic [DW-1:0] icb_rsp_rdata;
    logic          icb_rsp_err;

    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_sd;
    logic          ram_ds;
    logic          ram_ls;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready, ram_dout,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        input  ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_sd, ram_ds, ram_ls
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready, ram_dout,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        output ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_sd, ram_ds, ram_ls
    );
endinterface

// File: rtl/e203_dtcm_sram_ctrl.sv
// DTCM SRAM controller: ICB slave driving a single-port SRAM macro.
// One in-flight stage (read data arrives one cycle after cs) backed by a
// 2-entry response FIFO, plus idle-driven light-sleep control.
module e203_dtcm_sram_ctrl #(
    parameter int DP      = 65536,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MW      = 4,
    parameter int LS_IDLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    e203_dtcm_sram_ctrl_if.slave bus
);
    localparam int ICW = $clog2(LS_IDLE + 1);

    logic          infl_vld_q, infl_vld_d;
    logic          infl_read_q, infl_read_d;
    logic          infl_err_q, infl_err_d;

    logic [DW-1:0] fifo_rdata_q [2];
    logic          fifo_err_q   [2];
    logic          fifo_wptr_q, fifo_wptr_d;
    logic          fifo_rptr_q, fifo_rptr_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;

    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           ram_ls_q, ram_ls_d;

    logic          cmd_hs;
    logic          cmd_in_range;
    logic          rsp_hs;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          idle_cycle;
    logic [DW-1:0] infl_rdata;

    // Command side: accept only when not asleep and fewer than two responses are owed.
    assign cmd_in_range      = ({1'b0, bus.icb_cmd_addr} < (AW+1)'(DP));
    assign bus.icb_cmd_ready = ~ram_ls_q & (({1'b0, fifo_cnt_q} + {2'b00, infl_vld_q}) < 3'd2);
    assign cmd_hs            = bus.icb_cmd_valid & bus.icb_cmd_ready;

    // SRAM strobes are only active in a handshake cycle for an in-range address.
    assign bus.ram_cs   = cmd_hs & cmd_in_range;
    assign bus.ram_we   = bus.ram_cs & ~bus.icb_cmd_read;
    assign bus.ram_wem  = bus.ram_we ? bus.icb_cmd_wmask : '0;
    assign bus.ram_addr = bus.icb_cmd_addr;
    assign bus.ram_din  = bus.icb_cmd_wdata;
    assign bus.ram_sd   = 1'b0;
    assign bus.ram_ds   = 1'b0;
    assign bus.ram_ls   = ram_ls_q;

    // Response side: FIFO head has priority, else flow-through from the in-flight stage.
    assign fifo_empty        = (fifo_cnt_q == 2'd0);
    assign infl_rdata        = (infl_vld_q & infl_read_q & ~infl_err_q) ? bus.ram_dout : '0;
    assign bus.icb_rsp_valid = ~fifo_empty | infl_vld_q;
    assign bus.icb_rsp_rdata = fifo_empty ? infl_rdata : fifo_rdata_q[fifo_rptr_q];
    assign bus.icb_rsp_err   = fifo_empty ? (infl_vld_q & infl_err_q) : fifo_err_q[fifo_rptr_q];
    assign rsp_hs            = bus.icb_rsp_valid & bus.icb_rsp_ready;

    // An in-flight entry not consumed directly parks in the FIFO so its read data survives.
    assign fifo_pop   = rsp_hs & ~fifo_empty;
    assign fifo_push  = infl_vld_q & ~(rsp_hs & fifo_empty);
    assign idle_cycle = ~bus.icb_cmd_valid & ~infl_vld_q & fifo_empty;

    // Next-state for in-flight stage, FIFO pointers, idle counter and sleep flag.
    always_comb begin
        infl_vld_d  = cmd_hs;
        infl_read_d = bus.icb_cmd_read;
        infl_err_d  = ~cmd_in_range;
        fifo_wptr_d = fifo_wptr_q ^ fifo_push;
        fifo_rptr_d = fifo_rptr_q ^ fifo_pop;
        fifo_cnt_d  = fifo_cnt_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
        idle_cnt_d  = '0;
        if (idle_cycle) begin
            idle_cnt_d = (idle_cnt_q == ICW'(LS_IDLE)) ? idle_cnt_q : idle_cnt_q + ICW'(1);
        end
        ram_ls_d = ram_ls_q;
        if (bus.icb_cmd_valid) begin
            ram_ls_d = 1'b0;
        end else if (idle_cnt_q == ICW'(LS_IDLE)) begin
            ram_ls_d = 1'b1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_vld_q  <= 1'b0;
            infl_read_q <= 1'b0;
            infl_err_q  <= 1'b0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            idle_cnt_q  <= '0;
            ram_ls_q    <= 1'b0;
        end else begin
            infl_vld_q  <= infl_vld_d;
            infl_read_q <= infl_read_d;
            infl_err_q  <= infl_err_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            ram_ls_q    <= ram_ls_d;
        end
    end

    // FIFO payload storage; occupancy is tracked by fifo_cnt_q so no reset is needed.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo_entry
        always_ff @(posedge clk) begin
            if (fifo_push && (fifo_wptr_q == 1'(gi))) begin
                fifo_rdata_q[gi] <= infl_rdata;
                fifo_err_q[gi]   <= infl_err_q;
            end
        end
    end
endmodule

// File: tb/tb_e203_dtcm_sram_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, scoreboard-checked.
module tb_e203_dtcm_sram_ctrl;
    localparam int DP      = 1024;
    localparam int DAW     = 10;
    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int MW      = 4;
    localparam int LS_IDLE = 4;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rsp_num  = 0;
    logic last_cs  = 1'b0;

    rsp_t exp_q[$];
    int   pop_cyc_q[$];
    logic [DW-1:0] ram_mem [DP] = '{default: '0};
    logic [DW-1:0] ref_mem [DP] = '{default: '0};

    e203_dtcm_sram_ctrl_if #(.AW(AW), .DW(DW), .MW(MW)) bus ();

    e203_dtcm_sram_ctrl #(
        .DP(DP), .AW(AW), .DW(DW), .MW(MW), .LS_IDLE(LS_IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM macro model: synchronous write with byte enables, registered read.
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) begin
                for (int b = 0; b < MW; b++)
                    if (bus.ram_wem[b]) ram_mem[bus.ram_addr[DAW-1:0]][8*b +: 8] <= bus.ram_din[8*b +: 8];
            end else begin
                bus.ram_dout <= ram_mem[bus.ram_addr[DAW-1:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus side: check command-side outputs and record expected responses.
    always @(negedge clk) begin : sampler
        logic hs;
        logic inr;
        rsp_t e;
        int   a;
        if (rst) begin
            exp_q.delete();
        end else begin
            hs  = bus.icb_cmd_valid & bus.icb_cmd_ready;
            a   = int'(bus.icb_cmd_addr);
            inr = (a < DP);
            if (bus.ram_ls) chk("ready_while_asleep", {31'd0, bus.icb_cmd_ready}, 32'd0);
            else chk("ready_vs_outstanding", {31'd0, bus.icb_cmd_ready}, {31'd0, exp_q.size() < 2});
            chk("ram_cs", {31'd0, bus.ram_cs}, {31'd0, hs & inr});
            if (hs & inr) begin
                chk("ram_we", {31'd0, bus.ram_we}, {31'd0, ~bus.icb_cmd_read});
                chk("ram_wem", {28'd0, bus.ram_wem}, bus.icb_cmd_read ? 32'd0 : {28'd0, bus.icb_cmd_wmask});
                chk("ram_addr", {16'd0, bus.ram_addr}, {16'd0, bus.icb_cmd_addr});
                chk("ram_din", bus.ram_din, bus.icb_cmd_wdata);
            end else begin
                chk("ram_we_idle", {31'd0, bus.ram_we}, 32'd0);
                chk("ram_wem_idle", {28'd0, bus.ram_wem}, 32'd0);
            end
            chk("ram_sd_ds", {30'd0, bus.ram_sd, bus.ram_ds}, 32'd0);
            if (hs) begin
                e.err   = 1'b0;
                e.rdata = '0;
                if (!inr) begin
                    e.err = 1'b1;
                end else if (bus.icb_cmd_read) begin
                    e.rdata = ref_mem[a];
                end else begin
                    for (int b = 0; b < MW; b++)
                        if (bus.icb_cmd_wmask[b]) ref_mem[a][8*b +: 8] = bus.icb_cmd_wdata[8*b +: 8];
                end
                exp_q.push_back(e);
            end
        end
    end

    // Response monitor: pops the scoreboard on each rsp handshake, checks hold during stalls.
    always @(negedge clk) begin : monitor
        logic prev_stall;
        rsp_t prev;
        rsp_t e;
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("rsp_hold_valid", {31'd0, bus.icb_rsp_valid}, 32'd1);
                chk("rsp_hold_rdata", bus.icb_rsp_rdata, prev.rdata);
                chk("rsp_hold_err", {31'd0, bus.icb_rsp_err}, {31'd0, prev.err});
            end
            if (bus.icb_rsp_valid && bus.icb_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_without_cmd", {31'd0, exp_q.size() != 0}, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", bus.icb_rsp_rdata, e.rdata);
                    chk("rsp_err", {31'd0, bus.icb_rsp_err}, {31'd0, e.err});
                    pop_cyc_q.push_back(cyc);
                    rsp_num++;
                    $display("rsp %0d: rdata=0x%08h err=%0d cycle=%0d", rsp_num, bus.icb_rsp_rdata, bus.icb_rsp_err, cyc);
                end
            end
            prev_stall = bus.icb_rsp_valid & ~bus.icb_rsp_ready;
            prev.rdata = bus.icb_rsp_rdata;
            prev.err   = bus.icb_rsp_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command until accepted (bounded); returns number of cycles it was offered.
    task automatic issue(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [MW-1:0] m, output int tries);
        logic hs;
        bus.icb_cmd_valid = 1'b1;
        bus.icb_cmd_read  = rd;
        bus.icb_cmd_addr  = a;
        bus.icb_cmd_wdata = d;
        bus.icb_cmd_wmask = m;
        tries = 0;
        do begin
            #2;
            hs      = bus.icb_cmd_valid & bus.icb_cmd_ready;
            last_cs = bus.ram_cs;
            tick();
            tries++;
        end while (!hs && tries < 20);
        if (!hs) chk("issue_timeout", tries, 32'd0);
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        bus.icb_cmd_valid = 1'b0;
        bus.icb_cmd_read  = 1'b0;
        bus.icb_cmd_addr  = '0;
        bus.icb_cmd_wdata = '0;
        bus.icb_cmd_wmask = '0;
        bus.icb_rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("reset_rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", bus.icb_rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, bus.icb_rsp_err}, 32'd0);
        chk("reset_ram_cs", {31'd0, bus.ram_cs}, 32'd0);
        chk("reset_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd1);
        chk("reset_ram_ls", {31'd0, bus.ram_ls}, 32'd0);
        rst = 1'b0;

        // Write then read back with one-cycle latency
        issue(1'b0, AW'(16'h10), 32'hDEADBEEF, 4'hF, t);
        issue(1'b1, AW'(16'h10), '0, '0, t);
        chk("rd_latency_valid", {31'd0, bus.icb_rsp_valid}, 32'd1);
        chk("rd_latency_rdata", bus.icb_rsp_rdata, 32'hDEADBEEF);
        chk("rd_latency_err", {31'd0, bus.icb_rsp_err}, 32'd0);

        // Back-to-back: fill four words, then four reads at full rate
        for (int i = 0; i < 4; i++) issue(1'b0, AW'(32 + i), 32'hA5A50000 + i, 4'hF, t);
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, AW'(32 + i), '0, '0, t);
            chk("b2b_accept_tries", t, 32'd1);
        end
        bus.icb_cmd_valid = 1'b0;
        repeat (3) tick();
        n = pop_cyc_q.size();
        for (int k = n - 3; k < n; k++) chk("b2b_consecutive_rsp", pop_cyc_q[k] - pop_cyc_q[k-1], 32'd1);

        // Backpressure: two accepted, third held off until the consumer drains
        bus.icb_rsp_ready = 1'b0;
        issue(1'b1, AW'(32), '0, '0, t);
        issue(1'b1, AW'(33), '0, '0, t);
        bus.icb_cmd_read = 1'b1;
        bus.icb_cmd_addr = AW'(34);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd0);
            tick();
        end
        bus.icb_rsp_ready = 1'b1;
        issue(1'b1, AW'(34), '0, '0, t);
        chk("resume_tries", t, 32'd2);
        bus.icb_cmd_valid = 1'b0;
        repeat (3) tick();
        n = pop_cyc_q.size();
        for (int k = n - 2; k < n; k++) chk("resume_consecutive_rsp", pop_cyc_q[k] - pop_cyc_q[k-1], 32'd1);

        // Out-of-range read
        issue(1'b1, AW'(DP), '0, '0, t);
        chk("oor_ram_cs", {31'd0, last_cs}, 32'd0);
        chk("oor_rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd1);
        chk("oor_rsp_err", {31'd0, bus.icb_rsp_err}, 32'd1);
        chk("oor_rsp_rdata", bus.icb_rsp_rdata, 32'd0);

        // Light sleep entry after LS_IDLE+1 idle cycles, then one-cycle wake penalty
        issue(1'b0, AW'(48), 32'h12345678, 4'h5, t);
        bus.icb_cmd_valid = 1'b0;
        for (int i = 0; i < LS_IDLE + 1; i++) tick();
        chk("ls_not_yet", {31'd0, bus.ram_ls}, 32'd0);
        tick();
        chk("ls_entered", {31'd0, bus.ram_ls}, 32'd1);
        chk("ls_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd0);
        issue(1'b1, AW'(48), '0, '0, t);
        chk("wake_tries", t, 32'd2);
        chk("wake_ls_cleared", {31'd0, bus.ram_ls}, 32'd0);
        bus.icb_cmd_valid = 1'b0;
        repeat (2) tick();

        // Reset with two responses pending
        bus.icb_rsp_ready = 1'b0;
        issue(1'b1, AW'(16'h10), '0, '0, t);
        issue(1'b1, AW'(32), '0, '0, t);
        bus.icb_cmd_valid = 1'b0;
        tick();
        chk("pending_rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'd0, bus.icb_cmd_ready}, 32'd1);
        rst = 1'b0;
        tick();
        chk("postrst_rsp_valid", {31'd0, bus.icb_rsp_valid}, 32'd0);
        bus.icb_rsp_ready = 1'b1;
        issue(1'b1, AW'(16'h10), '0, '0, t);
        bus.icb_cmd_valid = 1'b0;
        repeat (2) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.icb_rsp_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6) begin
                bus.icb_cmd_valid = 1'b1;
                bus.icb_cmd_read  = 1'($urandom_range(0, 1));
                bus.icb_cmd_addr  = ($urandom_range(0, 15) == 0) ? AW'(DP + $urandom_range(0, 3))
                                                                : AW'($urandom_range(0, 31));
                bus.icb_cmd_wdata = $urandom;
                bus.icb_cmd_wmask = MW'($urandom_range(0, 15));
            end else begin
                bus.icb_cmd_valid = 1'b0;
            end
            tick();
        end

        // Drain
        bus.icb_cmd_valid = 1'b0;
        bus.icb_rsp_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
